// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_arbiter
//  Description : Shares one external memory bus between the CPU fetch port and
//                the data port. Data wins by default. After STARVE_MAX data
//                grants in a row while a fetch is waiting, the fetch is served.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_bus_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic [31:0]       i_q,
  output logic              i_done,
  input  logic              d_re,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_data,
  output logic [31:0]       d_q,
  output logic              d_done,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_data,
  output logic              bus_we,
  output logic              bus_start,
  input  logic [31:0]       bus_q,
  input  logic              bus_done,
  output logic [1:0]        grant
);

  localparam logic [3:0] STARVE_LIM  = 4'(STARVE_MAX);
  localparam logic [1:0] GRANT_NONE  = 2'b00;
  localparam logic [1:0] GRANT_FETCH = 2'b01;
  localparam logic [1:0] GRANT_DATA  = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] starve_cnt;
  logic       dreq;
  logic       fetch_starved;
  logic       take_data;
  logic       take_fetch;

  // Arbitration decision; only acted upon while IDLE.
  always_comb begin
    dreq          = d_re | d_we;
    fetch_starved = i_req && (starve_cnt == STARVE_LIM);
    take_data     = dreq && !fetch_starved;
    take_fetch    = !take_data && i_req;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; bus_done only matters while waiting on memory.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (take_data || take_fetch) state_next = START;
      START:   state_next = WAIT;
      WAIT:    if (bus_done) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Pulses decoded straight from the state so reset clears them at once.
  assign bus_start = (state == START);
  assign i_done    = (state == DONE) && (grant == GRANT_FETCH);
  assign d_done    = (state == DONE) && (grant == GRANT_DATA);

  // Starvation counter: counts data grants that overtake a waiting fetch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= 4'd0;
    end else if (state == IDLE) begin
      if (!i_req || take_fetch) begin
        starve_cnt <= 4'd0;
      end else if (take_data && (starve_cnt != STARVE_LIM)) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

  // Transfer latches and read-data capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_addr <= '0;
      bus_data <= 32'd0;
      bus_we   <= 1'b0;
      grant    <= GRANT_NONE;
      i_q      <= 32'd0;
      d_q      <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (take_data) begin
            bus_addr <= d_addr[ADDR_W-1:0];
            bus_data <= d_data;
            // A combined read+write is executed as a write.
            bus_we   <= d_we;
            grant    <= GRANT_DATA;
          end else if (take_fetch) begin
            bus_addr <= i_addr[ADDR_W-1:0];
            bus_we   <= 1'b0;
            grant    <= GRANT_FETCH;
          end
        end
        WAIT: begin
          if (bus_done) begin
            if (grant == GRANT_FETCH) begin
              i_q <= bus_q;
            end else if (!bus_we) begin
              d_q <= bus_q;
            end
          end
        end
        DONE:    grant <= GRANT_NONE;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_bus_arbiter
//  Description : Randomized scoreboard bench for mem_bus_arbiter with a
//                behavioural memory and a rule-level arbitration model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_bus_arbiter;

  localparam int ADDR_W     = 32;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_req;
  logic [31:0]       i_addr;
  logic [31:0]       i_q;
  logic              i_done;
  logic              d_re;
  logic              d_we;
  logic [31:0]       d_addr;
  logic [31:0]       d_data;
  logic [31:0]       d_q;
  logic              d_done;
  logic [ADDR_W-1:0] bus_addr;
  logic [31:0]       bus_data;
  logic              bus_we;
  logic              bus_start;
  logic [31:0]       bus_q;
  logic              bus_done;
  logic [1:0]        grant;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_q(i_q), .i_done(i_done),
    .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_data(d_data),
    .d_q(d_q), .d_done(d_done),
    .bus_addr(bus_addr), .bus_data(bus_data), .bus_we(bus_we),
    .bus_start(bus_start), .bus_q(bus_q), .bus_done(bus_done),
    .grant(grant)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          starve_fetches = 0;
  logic [31:0] iq_exp[$];
  logic [31:0] dq_exp[$];
  logic [31:0] mem     [16];
  logic [31:0] ref_mem [16];
  logic [31:0] last_dq = 32'd0;
  logic        real_done = 1'b0;

  function automatic logic [31:0] rom_val(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return (a * 32'h0100_0193) + 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory: random latency 1..4, stray bus_done in idle/start/done cycles.
  initial begin : memory_model
    int          countdown;
    logic [31:0] a;
    logic        w;
    countdown = 0;
    a = 32'd0;
    w = 1'b0;
    bus_done = 1'b0;
    bus_q    = 32'd0;
    forever begin
      @(posedge clk); #1;
      bus_done  = 1'b0;
      real_done = 1'b0;
      if (!reset) begin
        countdown = 0;
      end else if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          bus_done  = 1'b1;
          real_done = 1'b1;
          bus_q = w ? $urandom : ((a[31:12] == 20'h2) ? mem[a[5:2]] : rom_val(a));
        end
      end else if (bus_start) begin
        a = 32'(bus_addr);
        w = bus_we;
        if (w && a[31:12] == 20'h2) mem[a[5:2]] = bus_data;
        countdown = $urandom_range(1, 4);
        if ($urandom_range(0, 2) == 0) begin
          bus_done = 1'b1;
          bus_q    = $urandom;
        end
      end else if ($urandom_range(0, 5) == 0) begin
        bus_done = 1'b1;
        bus_q    = $urandom;
      end
    end
  end

  // Monitor: arbitration rule check at each bus_start, scoreboard pops on done.
  initial begin : monitor
    logic        pi, pd, pwe, prev_real;
    logic [31:0] pia, pda, pdd;
    int          cnt_m;
    pi = 0; pd = 0; pwe = 0; prev_real = 0;
    pia = 0; pda = 0; pdd = 0; cnt_m = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        cnt_m = 0; pi = 0; pd = 0; prev_real = 0;
      end else begin
        if (bus_start) begin
          if (!pd && !pi) begin
            chk("start_without_request", 64'(1), 64'(0));
          end else if (pd && !(pi && cnt_m == STARVE_MAX)) begin
            chk("grant_data", 64'(grant), 64'(2'b10));
            chk("bus_we_data", 64'(bus_we), 64'(pwe));
            chk("bus_addr_data", 64'(bus_addr), 64'(pda));
            if (pwe) chk("bus_data", 64'(bus_data), 64'(pdd));
            cnt_m = pi ? ((cnt_m < STARVE_MAX) ? cnt_m + 1 : cnt_m) : 0;
          end else begin
            chk("grant_fetch", 64'(grant), 64'(2'b01));
            chk("bus_we_fetch", 64'(bus_we), 64'(0));
            chk("bus_addr_fetch", 64'(bus_addr), 64'(pia));
            if (pd) starve_fetches++;
            cnt_m = 0;
          end
        end
        if (i_done || d_done || prev_real)
          chk("done_timing", 64'(i_done | d_done), 64'(prev_real));
        if (i_done) begin
          if (iq_exp.size() == 0) chk("i_done_unexpected", 64'(1), 64'(0));
          else chk("i_q", 64'(i_q), 64'(iq_exp.pop_front()));
        end
        if (d_done) begin
          if (dq_exp.size() == 0) chk("d_done_unexpected", 64'(1), 64'(0));
          else chk("d_q", 64'(d_q), 64'(dq_exp.pop_front()));
        end
        prev_real = real_done;
        pi = i_req; pd = d_re | d_we; pwe = d_we;
        pia = i_addr; pda = d_addr; pdd = d_data;
      end
    end
  end

  task automatic wait_for(input bit is_fetch, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (is_fetch ? i_done : d_done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk(is_fetch ? "fetch_timeout" : "data_timeout", 64'(0), 64'(1));
  endtask

  task automatic fetch_txn(input logic [31:0] addr);
    bit ok;
    i_addr = addr;
    i_req  = 1'b1;
    iq_exp.push_back(rom_val(addr));
    wait_for(1'b1, ok);
    @(posedge clk); #1;
    i_req = 1'b0;
  endtask

  // kind: 0 read, 1 write, 2 read+write (behaves as write, d_q unchanged)
  task automatic data_txn(input int kind, input int idx, input logic [31:0] wdata);
    bit ok;
    d_addr = 32'h2000 + 32'(idx) * 4;
    d_data = wdata;
    d_re   = (kind != 1);
    d_we   = (kind != 0);
    if (kind == 0) last_dq = ref_mem[idx];
    else ref_mem[idx] = wdata;
    dq_exp.push_back(last_dq);
    wait_for(1'b0, ok);
    @(posedge clk); #1;
    d_re = 1'b0;
    d_we = 1'b0;
  endtask

  task automatic data_proc(input int n, input int maxgap);
    int r;
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(0, maxgap)) begin @(posedge clk); #1; end
      r = $urandom_range(0, 9);
      data_txn((r < 5) ? 0 : ((r < 8) ? 1 : 2), $urandom_range(0, 15), $urandom);
    end
  endtask

  task automatic fetch_proc(input int n, input int maxgap);
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(0, maxgap)) begin @(posedge clk); #1; end
      fetch_txn(32'h100 + 32'($urandom_range(0, 31)) * 4);
    end
  endtask

  initial begin : main
    bit seen;
    reset = 1'b0; i_req = 1'b0; i_addr = 32'd0;
    d_re = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_data = 32'd0;
    for (int i = 0; i < 16; i++) begin
      mem[i]     = 32'hA000_0000 + 32'(i);
      ref_mem[i] = 32'hA000_0000 + 32'(i);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_bus_start", 64'(bus_start), 64'(0));
    chk("rst_bus_addr", 64'(bus_addr), 64'(0));
    chk("rst_bus_data", 64'(bus_data), 64'(0));
    chk("rst_bus_we", 64'(bus_we), 64'(0));
    chk("rst_q", 64'({i_q, d_q}), 64'(0));
    chk("rst_done", 64'({i_done, d_done}), 64'(0));
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #1;

    // Single fetch, then simultaneous data write + fetch, then read / read+write.
    fetch_txn(32'h100);
    fork
      fetch_txn(32'h104);
      data_txn(1, 2, 32'h55);
    join
    data_txn(1, 3, 32'h1234);
    data_txn(0, 3, 32'h0);
    data_txn(2, 5, 32'hBEEF);

    // Random traffic, then saturated traffic that forces the starvation guard.
    fork
      data_proc(40, 3);
      fetch_proc(40, 3);
    join
    fork
      data_proc(30, 0);
      fetch_proc(8, 0);
    join
    chk("starvation_fetch_seen", 64'(starve_fetches > 0), 64'(1));

    // Reset while waiting on memory; pending fetch restarts after release.
    i_addr = 32'h104;
    i_req  = 1'b1;
    seen   = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus_start) begin seen = 1'b1; break; end
    end
    chk("reset_test_start_seen", 64'(seen), 64'(1));
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_grant", 64'(grant), 64'(0));
    chk("midrst_bus", 64'({bus_start, bus_we}), 64'(0));
    chk("midrst_bus_addr", 64'(bus_addr), 64'(0));
    chk("midrst_i_q", 64'(i_q), 64'(0));
    chk("midrst_done", 64'({i_done, d_done}), 64'(0));
    repeat (2) @(posedge clk);
    iq_exp.push_back(rom_val(32'h104));
    #2;
    reset = 1'b1;
    chk("release_no_start", 64'(bus_start), 64'(0));
    @(posedge clk); #1;
    chk("restart_bus_start", 64'(bus_start), 64'(1));
    wait_for(1'b1, seen);
    @(posedge clk); #1;
    i_req = 1'b0;
    repeat (4) @(posedge clk);

    chk("iq_exp_drained", 64'(iq_exp.size()), 64'(0));
    chk("dq_exp_drained", 64'(dq_exp.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
